// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: IF-stage FSM state encodings and the default NOP word.
package if_fetch_unit_pkg;
  localparam int IF_STATE_BUS = 2;
  typedef enum logic [IF_STATE_BUS-1:0] {
    IF_STATE_FETCH,
    IF_STATE_SKID,
    IF_STATE_DISCARD
  } if_state_e;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0;
endpackage

// File: rtl/if_fetch_unit_if_reg.sv
// if_reg: IF pipeline register; squash beats stall, stall beats load, otherwise a bubble is inserted.
module if_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(NOP_INSN_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              squash_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] insn_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_insn_o,
  output logic              if_en_o
);
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] insn_q;
  logic              en_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      insn_q <= NOP_INSN;
      en_q   <= 1'b0;
    end else if (squash_i) begin
      insn_q <= NOP_INSN;
      en_q   <= 1'b0;
    end else if (!stall_i) begin
      en_q   <= load_i;
      insn_q <= load_i ? insn_i : NOP_INSN;
      if (load_i) pc_q <= pc_i;
    end
  end
  assign if_pc_o   = pc_q;
  assign if_insn_o = insn_q;
  assign if_en_o   = en_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage owning the PC, bus handshake, skid buffer and IF register.
// Define IF_PERF_CNT_EN to build the fetch/wait performance counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(NOP_INSN_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  output logic              if_bus_req_o,
  output logic [ADDR_W-1:0] if_bus_addr_o,
  input  logic              if_bus_rdy_i,
  input  logic [DATA_W-1:0] if_bus_rd_data_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_insn_o,
  output logic              if_en_o,
  output logic [31:0]       if_fetch_cnt_o,
  output logic [31:0]       if_wait_cnt_o
);
  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, redir_pc_q, redir_pc_d, skid_pc_q, skid_pc_d, tgt;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              redir, load, in_skid;
  assign redir         = flush_i | (br_taken_i & ~stall_i);
  assign tgt           = flush_i ? new_pc_i : br_addr_i;
  assign in_skid       = state_q == IF_STATE_SKID;
  assign if_bus_req_o  = ~reset & ~in_skid;
  assign if_bus_addr_o = pc_q;
  assign load          = ~redir & ~stall_i & (in_skid | (state_q == IF_STATE_FETCH & if_bus_rdy_i));
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    case (state_q)
      IF_STATE_FETCH: begin
        if (redir) begin
          // An outstanding bus cycle cannot be aborted, so a redirect must wait it out in DISCARD
          if (if_bus_rdy_i) pc_d = tgt;
          else begin
            redir_pc_d = tgt;
            state_d    = IF_STATE_DISCARD;
          end
        end else if (if_bus_rdy_i) begin
          pc_d = pc_q + ADDR_W'(1);
          if (stall_i) begin
            skid_d    = if_bus_rd_data_i;
            skid_pc_d = pc_q;
            state_d   = IF_STATE_SKID;
          end
        end
      end
      IF_STATE_SKID: begin
        if (redir) pc_d = tgt;
        if (redir || !stall_i) state_d = IF_STATE_FETCH;
      end
      default: begin
        if (redir) redir_pc_d = tgt;
        if (if_bus_rdy_i) begin
          pc_d    = redir ? tgt : redir_pc_q;
          state_d = IF_STATE_FETCH;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IF_STATE_FETCH;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
      skid_pc_q  <= RESET_PC;
      skid_q     <= NOP_INSN;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      skid_pc_q  <= skid_pc_d;
      skid_q     <= skid_d;
    end
  end
  if_reg #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)
  ) u_if_reg (
    .clk      (clk),
    .reset    (reset),
    .squash_i (redir),
    .stall_i  (stall_i),
    .load_i   (load),
    .pc_i     (in_skid ? skid_pc_q : pc_q),
    .insn_i   (in_skid ? skid_q : if_bus_rd_data_i),
    .if_pc_o  (if_pc_o),
    .if_insn_o(if_insn_o),
    .if_en_o  (if_en_o)
  );
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, wait_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (if_bus_req_o && !if_bus_rdy_i) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end
  assign if_fetch_cnt_o = fetch_cnt_q;
  assign if_wait_cnt_o  = wait_cnt_q;
`else
  assign if_fetch_cnt_o = '0;
  assign if_wait_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: transaction-level reference model feeds a scoreboard; a monitor checks each IF-register load.
module tb_if_fetch_unit;
  typedef struct {
    logic [29:0] pc;
    logic [31:0] insn;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, br_taken = 1'b0, rdy = 1'b0;
  logic [29:0] new_pc = '0, br_addr = '0;
  logic [31:0] rd_data = '0;
  logic        req, if_en;
  logic [29:0] addr, if_pc;
  logic [31:0] if_insn, fetch_cnt, wait_cnt;
  int          n_chk = 0, n_pass = 0;
  exp_t        sb[$];
  logic        m_held, m_kill, stall_e;
  logic [29:0] m_addr, m_tgt, m_hpc;
  int unsigned m_fetch, m_wait;
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall_i(stall), .flush_i(flush), .new_pc_i(new_pc),
    .br_taken_i(br_taken), .br_addr_i(br_addr), .if_bus_req_o(req), .if_bus_addr_o(addr),
    .if_bus_rdy_i(rdy), .if_bus_rd_data_i(rd_data), .if_pc_o(if_pc), .if_insn_o(if_insn),
    .if_en_o(if_en), .if_fetch_cnt_o(fetch_cnt), .if_wait_cnt_o(wait_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic model_reset();
    m_held = 1'b0; m_kill = 1'b0; m_addr = '0; m_tgt = '0; m_hpc = '0;
    m_fetch = 0; m_wait = 0;
  endtask
  task automatic push(input logic [29:0] pc);
    exp_t e;
    e.pc = pc; e.insn = mem_f(pc);
    sb.push_back(e);
    m_fetch++;
  endtask
  task automatic check_counters();
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("wait_cnt", wait_cnt, m_wait);
`else
    chk("fetch_cnt_off", fetch_cnt, 0);
    chk("wait_cnt_off", wait_cnt, 0);
`endif
  endtask
  // One clock of stimulus, entered and left at a falling edge.
  task automatic step(input logic s, input logic f, input logic b, input logic [29:0] ba,
                      input logic [29:0] np, input logic r);
    logic redir;
    logic [29:0] t;
    stall = s; flush = f; br_taken = b; br_addr = ba; new_pc = np; rdy = r;
    rd_data = mem_f(addr);
    redir = f | (b & ~s);
    t = f ? np : ba;
    #1;
    chk("bus_req", req, !m_held);
    if (!m_held) chk("bus_addr", addr, m_addr);
    if (m_held) begin
      if (redir) begin m_held = 1'b0; m_addr = t; end
      else if (!s) begin push(m_hpc); m_held = 1'b0; end
    end else if (r) begin
      if (redir || m_kill) begin m_addr = redir ? t : m_tgt; m_kill = 1'b0; end
      else if (s) begin m_held = 1'b1; m_hpc = m_addr; m_addr = m_addr + 30'd1; end
      else begin push(m_addr); m_addr = m_addr + 30'd1; end
    end else begin
      m_wait++;
      if (redir) begin m_kill = 1'b1; m_tgt = t; end
    end
    @(negedge clk);
  endtask
  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [29:0] ba, np;
      ba = ($urandom % 4 == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      np = 30'($urandom);
      step($urandom % 4 == 0, $urandom % 16 == 0, $urandom % 8 == 0, ba, np, $urandom % 3 != 0);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      stall_e = stall;
      #2;
      if (!reset) begin
        if (!stall_e && if_en) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_load: got pc %0h, expected no load", if_pc);
          end else begin
            e = sb.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_insn", if_insn, e.insn);
          end
        end
        if (!stall_e) chk("sb_drained", sb.size(), 0);
        if (!if_en) chk("bubble_nop", if_insn, 32'h0);
      end
    end
  end
  initial begin
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_en", if_en, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_insn", if_insn, 0);
    check_counters();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 30'h40, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 30'h40, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 30'h40, 30'h100, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 30'h3FFF_FFFF, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    check_counters();
    rand_steps(2000);
    check_counters();
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b1; rdy = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_req", req, 0);
    chk("mid_rst_en", if_en, 0);
    chk("mid_rst_addr", addr, 0);
    check_counters();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    rand_steps(500);
    check_counters();
    step(0, 0, 0, 0, 0, 0);
    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
